// File: rtl/sync_ram_arbiter.sv
// sync_ram_arbiter
//   Shares one single-ported synchronous-read RAM (1-cycle registered read)
//   between two requesters with valid/ready request handshakes.
//   Arbitration is round-robin with at most one access per cycle.
//   Read data goes back to the issuing port exactly one cycle after acceptance.
//
//   Build option: define SYNC_RAM_ARB_FIXED_PRIO_EN to give port 1 fixed
//   priority over port 0 under contention. Port 0 can then starve.
//
// Ports
//   clk, rst                     clock; synchronous active-low reset (0 = reset)
//   pN_req_valid/ready           request handshake for port N (0 or 1)
//   pN_req_we/addr/wdata         request write flag, word address, write data
//   pN_resp_valid/rdata          read response, one cycle after a read transfer
//   ram_addr/ram_d/ram_we        drive to the shared RAM
//   ram_q                        registered RAM read data
module sync_ram_arbiter #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_we,
    input  logic [AWIDTH-1:0] p0_req_addr,
    input  logic [DWIDTH-1:0] p0_req_wdata,
    output logic              p0_resp_valid,
    output logic [DWIDTH-1:0] p0_resp_rdata,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_we,
    input  logic [AWIDTH-1:0] p1_req_addr,
    input  logic [DWIDTH-1:0] p1_req_wdata,
    output logic              p1_resp_valid,
    output logic [DWIDTH-1:0] p1_resp_rdata,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_d,
    output logic              ram_we,
    input  logic [DWIDTH-1:0] ram_q
);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    port_e last_gnt;
    logic  pend_valid;
    port_e pend_port;

    port_e gnt_port;
    logic  xfer;
    logic  sel_we;

    // Winner selection. When nobody is valid the winner falls back to port 0,
    // which also makes port 0's address/data appear on the RAM when idle.
    always_comb begin
        // NOTE: default assignment first so no path leaves gnt_port unassigned
        // (otherwise a latch is inferred).
        gnt_port = PORT0;
`ifdef SYNC_RAM_ARB_FIXED_PRIO_EN
        if (p1_req_valid) begin
            gnt_port = PORT1;
        end
`else
        if (p0_req_valid && p1_req_valid) begin
            gnt_port = (last_gnt == PORT0) ? PORT1 : PORT0;
        end else if (p1_req_valid) begin
            gnt_port = PORT1;
        end
`endif
    end

    // A transfer happens whenever anyone is valid outside reset; the winner
    // is always a valid port, so ready is never raised towards an idle port.
    assign xfer   = rst && (p0_req_valid || p1_req_valid);
    assign sel_we = (gnt_port == PORT1) ? p1_req_we : p0_req_we;

    assign p0_req_ready = xfer && (gnt_port == PORT0);
    assign p1_req_ready = xfer && (gnt_port == PORT1);

    assign ram_addr = (gnt_port == PORT1) ? p1_req_addr  : p0_req_addr;
    assign ram_d    = (gnt_port == PORT1) ? p1_req_wdata : p0_req_wdata;
    assign ram_we   = xfer && sel_we;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_gnt   <= PORT1;   // port 0 wins the first contention
            pend_valid <= 1'b0;
            pend_port  <= PORT0;
        end else begin
            pend_valid <= xfer && !sel_we;
            if (xfer) begin
                last_gnt  <= gnt_port;
                pend_port <= gnt_port;
            end
        end
    end

    // Gated by rst so a response still pending when reset asserts is dropped.
    assign p0_resp_valid = rst && pend_valid && (pend_port == PORT0);
    assign p1_resp_valid = rst && pend_valid && (pend_port == PORT1);
    assign p0_resp_rdata = ram_q;
    assign p1_resp_rdata = ram_q;

endmodule

// File: tb/tb_sync_ram_arbiter.sv
// tb_sync_ram_arbiter
//   Directed bench for sync_ram_arbiter with a behavioural synchronous RAM
//   (write on posedge, registered old-data read). Inputs change 1 time unit
//   after posedge; outputs are checked on the following negedge.
//   Define SYNC_RAM_ARB_FIXED_PRIO_EN for both bench and RTL to run the
//   fixed-priority sequence instead of the round-robin one.
module tb_sync_ram_arbiter;

    localparam int DW = 32;
    localparam int AW = 12;

    logic          clk;
    logic          rst;
    logic          p0_req_valid, p0_req_ready, p0_req_we;
    logic [AW-1:0] p0_req_addr;
    logic [DW-1:0] p0_req_wdata;
    logic          p0_resp_valid;
    logic [DW-1:0] p0_resp_rdata;
    logic          p1_req_valid, p1_req_ready, p1_req_we;
    logic [AW-1:0] p1_req_addr;
    logic [DW-1:0] p1_req_wdata;
    logic          p1_resp_valid;
    logic [DW-1:0] p1_resp_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_d;
    logic          ram_we;
    logic [DW-1:0] ram_q;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    sync_ram_arbiter #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .p0_req_valid  (p0_req_valid),
        .p0_req_ready  (p0_req_ready),
        .p0_req_we     (p0_req_we),
        .p0_req_addr   (p0_req_addr),
        .p0_req_wdata  (p0_req_wdata),
        .p0_resp_valid (p0_resp_valid),
        .p0_resp_rdata (p0_resp_rdata),
        .p1_req_valid  (p1_req_valid),
        .p1_req_ready  (p1_req_ready),
        .p1_req_we     (p1_req_we),
        .p1_req_addr   (p1_req_addr),
        .p1_req_wdata  (p1_req_wdata),
        .p1_resp_valid (p1_resp_valid),
        .p1_resp_rdata (p1_resp_rdata),
        .ram_addr      (ram_addr),
        .ram_d         (ram_d),
        .ram_we        (ram_we),
        .ram_q         (ram_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural SYNC_RAM: old-data read, 1-cycle latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_d;
        ram_q <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic drive0(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p0_req_valid = v; p0_req_we = we; p0_req_addr = a; p0_req_wdata = d;
    endtask

    task automatic drive1(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p1_req_valid = v; p1_req_we = we; p1_req_addr = a; p1_req_wdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        drive0(1'b1, 1'b0, 12'h000, '0);
        drive1(1'b1, 1'b0, 12'h000, '0);

        // Reset held for 3 cycles with both ports requesting.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_p0_ready", p0_req_ready, 0);
            check("rst_p1_ready", p1_req_ready, 0);
            check("rst_ram_we", ram_we, 0);
            check("rst_p0_resp", p0_resp_valid, 0);
            check("rst_p1_resp", p1_resp_valid, 0);
            tick();
        end

        rst = 1'b1;
`ifdef SYNC_RAM_ARB_FIXED_PRIO_EN
        // Load 0x001=0x11 (p0) and 0x002=0x22 (p1), one port at a time.
        drive0(1'b1, 1'b1, 12'h001, 32'h11);
        drive1(1'b0, 1'b0, 12'h000, '0);
        @(negedge clk);
        check("fp_w0_ready", p0_req_ready, 1);
        tick();
        drive0(1'b0, 1'b0, 12'h000, '0);
        drive1(1'b1, 1'b1, 12'h002, 32'h22);
        @(negedge clk);
        check("fp_w1_ready", p1_req_ready, 1);
        tick();

        // Contention for 4 cycles: port 1 wins every time.
        drive0(1'b1, 1'b0, 12'h001, '0);
        drive1(1'b1, 1'b0, 12'h002, '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("fp_p1_ready", p1_req_ready, 1);
            check("fp_p0_ready", p0_req_ready, 0);
            if (k > 0) begin
                check("fp_p1_resp", p1_resp_valid, 1);
                check("fp_p1_rdata", p1_resp_rdata, 32'h22);
            end
            tick();
        end
        // Port 1 withdraws: port 0 finally gets through.
        drive1(1'b0, 1'b0, 12'h000, '0);
        @(negedge clk);
        check("fp_p0_ready_alone", p0_req_ready, 1);
        tick();
        drive0(1'b0, 1'b0, 12'h000, '0);
        @(negedge clk);
        check("fp_p0_resp", p0_resp_valid, 1);
        check("fp_p0_rdata", p0_resp_rdata, 32'h11);
`else
        // First contention after reset: port 0 wins. Both are writes.
        drive0(1'b1, 1'b1, 12'h001, 32'h11);
        drive1(1'b1, 1'b1, 12'h002, 32'h22);
        @(negedge clk);
        check("first_p0_ready", p0_req_ready, 1);
        check("first_p1_ready", p1_req_ready, 0);
        check("first_we", ram_we, 1);
        check("first_addr", ram_addr, 12'h001);
        tick();
        drive0(1'b0, 1'b0, 12'h000, '0);
        @(negedge clk);
        check("w1_p1_ready", p1_req_ready, 1);
        check("w1_addr", ram_addr, 12'h002);
        check("w1_d", ram_d, 32'h22);
        check("w1_no_resp", p0_resp_valid, 0);
        tick();

        // Continuous contention: p0,p1,p0,p1,p0,p1 with responses 1 cycle later.
        drive0(1'b1, 1'b0, 12'h001, '0);
        drive1(1'b1, 1'b0, 12'h002, '0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("cont_p0_ready", p0_req_ready, (k % 2) == 0);
            check("cont_p1_ready", p1_req_ready, (k % 2) == 1);
            check("cont_we", ram_we, 0);
            if (k > 0) begin
                check("cont_p0_resp", p0_resp_valid, (k % 2) == 1);
                check("cont_p1_resp", p1_resp_valid, (k % 2) == 0);
                check("cont_rdata", ram_q, ((k % 2) == 1) ? 32'h11 : 32'h22);
            end
            tick();
        end
        drive0(1'b0, 1'b0, 12'h000, '0);
        drive1(1'b0, 1'b0, 12'h000, '0);
        @(negedge clk);
        check("cont_last_p1_resp", p1_resp_valid, 1);
        check("cont_last_rdata", p1_resp_rdata, 32'h22);
        check("cont_last_p0_resp", p0_resp_valid, 0);
        check("idle_ready", p0_req_ready | p1_req_ready, 0);
        tick();

        // Single-port write then read of 0x010.
        drive0(1'b1, 1'b1, 12'h010, 32'hDEADBEEF);
        @(negedge clk);
        check("sp_w_ready", p0_req_ready, 1);
        check("sp_w_we", ram_we, 1);
        tick();
        drive0(1'b1, 1'b0, 12'h010, '0);
        @(negedge clk);
        check("sp_r_ready", p0_req_ready, 1);
        check("sp_r_we", ram_we, 0);
        check("sp_w_no_resp", p0_resp_valid, 0);
        tick();
        drive0(1'b0, 1'b0, 12'h000, '0);
        @(negedge clk);
        check("sp_resp", p0_resp_valid, 1);
        check("sp_rdata", p0_resp_rdata, 32'hDEADBEEF);
        check("sp_p1_resp", p1_resp_valid, 0);
        tick();

        // p1 read alone (last_gnt -> 1 so port 0 wins the next contention).
        drive1(1'b1, 1'b0, 12'h002, '0);
        @(negedge clk);
        check("h_pre_p1_ready", p1_req_ready, 1);
        tick();
        // Hold stability: p1 write waits while p0 is granted.
        drive0(1'b1, 1'b0, 12'h001, '0);
        drive1(1'b1, 1'b1, 12'h003, 32'hA5A5A5A5);
        @(negedge clk);
        check("h_pre_p1_resp", p1_resp_rdata, 32'h22);
        check("h_p0_ready", p0_req_ready, 1);
        check("h_p1_ready", p1_req_ready, 0);
        check("h_we", ram_we, 0);
        tick();
        drive0(1'b0, 1'b0, 12'h000, '0);
        @(negedge clk);
        check("h_p1_ready2", p1_req_ready, 1);
        check("h_we2", ram_we, 1);
        check("h_addr2", ram_addr, 12'h003);
        check("h_d2", ram_d, 32'hA5A5A5A5);
        check("h_p0_resp", p0_resp_valid, 1);
        check("h_p0_rdata", p0_resp_rdata, 32'h11);
        tick();
        drive1(1'b1, 1'b0, 12'h003, '0);
        @(negedge clk);
        check("h_rd_ready", p1_req_ready, 1);
        tick();
        drive1(1'b0, 1'b0, 12'h000, '0);
        @(negedge clk);
        check("h_rd_resp", p1_resp_valid, 1);
        check("h_rd_rdata", p1_resp_rdata, 32'hA5A5A5A5);
        tick();

        // Reset mid-read: p1 read accepted, then reset drops the response.
        drive1(1'b1, 1'b0, 12'h002, '0);
        @(negedge clk);
        check("mr_p1_ready", p1_req_ready, 1);
        tick();
        rst = 1'b0;
        drive1(1'b0, 1'b0, 12'h000, '0);
        @(negedge clk);
        check("mr_p1_resp_drop", p1_resp_valid, 0);
        tick();
        @(negedge clk);
        check("mr_p1_resp_after", p1_resp_valid, 0);
        tick();
        rst = 1'b1;
        drive0(1'b1, 1'b0, 12'h001, '0);
        drive1(1'b1, 1'b0, 12'h002, '0);
        @(negedge clk);
        check("mr_p0_wins", p0_req_ready, 1);
        check("mr_p1_waits", p1_req_ready, 0);
        check("mr_no_stale_resp", p1_resp_valid, 0);
        tick();
        drive0(1'b0, 1'b0, 12'h000, '0);
        drive1(1'b0, 1'b0, 12'h000, '0);
        @(negedge clk);
        check("mr_p0_resp", p0_resp_valid, 1);
        check("mr_p0_rdata", p0_resp_rdata, 32'h11);
`endif
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_ram_arbiter.md
Name: sync_ram_arbiter

Overview:
- Two-requester arbiter that shares one single-ported synchronous-read RAM (SYNC_RAM: write on posedge, registered read, 1-cycle read latency) between two masters, e.g. instruction fetch (port 0) and load/store (port 1).
- Arbitration is round-robin, at most one access per cycle, with valid/ready request handshakes.
- Returns read data to the issuing port exactly one cycle after acceptance.
- Sits between the CPU front-end/back-end and a shared RAM instance.

Parameters:
- DWIDTH, 32, data width of RAM and request ports
- AWIDTH, 12, word address width

Ports:
- clk  in  1  clock; all state on posedge
- rst  in  1  synchronous reset, active-low (0 = reset)
- p0_req_valid  in  1  port 0 request valid
- p0_req_ready  out  1  port 0 request accepted this cycle
- p0_req_we  in  1  port 0 write (1) / read (0)
- p0_req_addr  in  AWIDTH  port 0 word address
- p0_req_wdata  in  DWIDTH  port 0 write data
- p0_resp_valid  out  1  port 0 read data valid
- p0_resp_rdata  out  DWIDTH  port 0 read data
- p1_*  same set as p0_*, for port 1
- ram_addr  out  AWIDTH  to RAM addr
- ram_d  out  DWIDTH  to RAM d
- ram_we  out  1  to RAM we
- ram_q  in  DWIDTH  from RAM q (registered, 1-cycle latency)

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-low.
- Transfer rule: a transfer on port i occurs when pi_req_valid && pi_req_ready at a posedge. The requester holds valid/we/addr/wdata stable until the transfer. pi_req_ready is combinational from valids and arbiter state.
- State: last_gnt (1 bit), pend_valid (1 bit), pend_port (1 bit).
- Reset values: last_gnt=1 (port 0 wins first contention), pend_valid=0.
- Outputs while rst=0: p0/p1_req_ready=0, ram_we=0, p0/p1_resp_valid=0.
- Grant when rst=1:
  - Only one port valid: grant that port.
  - Both valid: grant port !last_gnt.
  - Neither valid: no grant.
  - Exactly one req_ready is high per cycle at most.
- last_gnt update: set to the granted port on every transfer; unchanged on idle cycles.
- RAM drive:
  - ram_addr/ram_d take the granted port's addr/wdata; port 0's when idle.
  - ram_we = transfer && granted we. A write never occurs without a transfer.
- Read response:
  - An accepted read sets pend_valid=1 and pend_port=granted port for the next cycle.
  - In that cycle p<pend_port>_resp_valid=1 and resp_rdata=ram_q. Latency is exactly 1 cycle.
  - There is no response backpressure; a requester must accept resp in that cycle.
  - pi_resp_rdata equals ram_q whenever pi_resp_valid=1; otherwise don't-care.
- Writes: no response. A read of the same address in the following cycle returns new data. A write followed by a read at the same address in back-to-back transfers is legal.
- Back-to-back accesses: full throughput, one transfer every cycle. Alternating grants under continuous contention give each port 50%.
- Reset mid-operation: a pending response is dropped (resp_valid=0 the cycle after rst falls and while rst=0). A request accepted in the same cycle rst=0 is ignored, because ready is forced 0.
- Read-during-write: RAM old-data semantics apply, but the arbiter never issues a simultaneous read and write.

Optional Feature:
- Macro: SYNC_RAM_ARB_FIXED_PRIO_EN.
- Defined: port 1 has fixed priority over port 0 under contention; last_gnt is ignored. Port 0 can starve.
- Undefined (default): round-robin as above.

Test Plan:
- Reset and idle: hold rst=0 for 3 cycles with both valids=1 -> both readys=0, ram_we=0, both resp_valid=0. Release rst -> port 0 granted first.
- Single-port write/read: p0 writes addr 0x010 data 0xDEADBEEF, next cycle p0 reads 0x010 -> p0_resp_valid=1 one cycle after the read transfer with rdata 0xDEADBEEF; p1_resp_valid stays 0.
- Contention: both ports read continuously (p0 addr 0x001 = 0x11, p1 addr 0x002 = 0x22) for 6 cycles -> grants p0,p1,p0,p1,p0,p1; responses alternate 0x11/0x22, each 1 cycle after its grant.
- Hold stability: p1 writes 0x003 = 0xA5A5A5A5 while p0 is granted -> p1 ready=0, ram_we=0 for p1 that cycle. Next cycle p1 is granted and the write completes; a subsequent read of 0x003 returns 0xA5A5A5A5.
- Reset mid-read: p1 read accepted, rst=0 the next cycle -> p1_resp_valid=0. After rst=1, state returns to last_gnt=1, so port 0 wins the next contention.
- Fixed-priority build (SYNC_RAM_ARB_FIXED_PRIO_EN): both ports valid for 4 cycles -> p1 granted all 4, p0_req_ready=0 throughout.
